// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Purpose:
//   32 x DATA_WIDTH architectural integer register file (x0..x31) with two
//   combinational read ports and one synchronous write port. x0 is hardwired
//   to zero. Reset loads the stack pointer (x2) and global pointer (x3) with
//   their parameterised start addresses and clears everything else.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When defined, a read port whose index matches an active write (rd != 0)
//   returns Write_Data_i in the same cycle, before the write edge.
//   When undefined, read ports return the stored value until the write edge.
//
// Ports:
//   clk               in   clock, all register updates on the rising edge
//   reset             in   asynchronous, active-high reset
//   Reg_Write_i       in   write enable from the write-back stage
//   Write_Register_i  in   [4:0] destination index rd
//   Write_Data_i      in   [DATA_WIDTH-1:0] write-back data
//   Read_Register_1_i in   [4:0] rs1 index
//   Read_Register_2_i in   [4:0] rs2 index
//   Read_Data_1_o     out  [DATA_WIDTH-1:0] rs1 value (ALU operand A)
//   Read_Data_2_o     out  [DATA_WIDTH-1:0] rs2 value (ALU operand B / store)
// -----------------------------------------------------------------------------
module register_file #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h7FFF_EFFC,
  parameter logic [DATA_WIDTH-1:0] GP_RESET   = 32'h1000_8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [4:0]            Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [4:0]            Read_Register_1_i,
  input  logic [4:0]            Read_Register_2_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

  // x0 has no storage at all, so a write to index 0 cannot leave a trace.
  logic [DATA_WIDTH-1:0] regs_q [1:31];
  logic [DATA_WIDTH-1:0] regs_d [1:31];
  logic [DATA_WIDTH-1:0] regView [0:31];
  logic                  writeEn;

  function automatic logic [DATA_WIDTH-1:0] resetValue(input int idx);
    if (idx == 2)
      return SP_RESET;
    else if (idx == 3)
      return GP_RESET;
    else
      return '0;
  endfunction

  // A write only counts when enabled, aimed at a real register and not
  // masked by reset (reset also suppresses the same-cycle bypass).
  assign writeEn = Reg_Write_i && (Write_Register_i != 5'd0) && !reset;

  // Next-state: compare against each index rather than indexing the array
  // directly, so index 0 simply matches nothing.
  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (writeEn && (Write_Register_i == 5'(i)))
        regs_d[i] = Write_Data_i;
    end
  end

  // Storage: reset is asynchronous and takes priority over any write edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= resetValue(i);
    end else begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= regs_d[i];
    end
  end

  // Full 32-entry view with x0 tied to zero so the read muxes use the raw index.
  always_comb begin
    regView[0] = '0;
    for (int i = 1; i < 32; i++)
      regView[i] = regs_q[i];
  end

  // Read ports are purely combinational from the index inputs.
  always_comb begin
    Read_Data_1_o = regView[Read_Register_1_i];
    Read_Data_2_o = regView[Read_Register_2_i];
`ifdef REGFILE_BYPASS_EN
    // writeEn already excludes index 0 and reset, so x0 never bypasses.
    if (writeEn && (Write_Register_i == Read_Register_1_i))
      Read_Data_1_o = Write_Data_i;
    if (writeEn && (Write_Register_i == Read_Register_2_i))
      Read_Data_2_o = Write_Data_i;
`else
    // Stored value is returned until the write edge.
`endif
  end

endmodule
